// File: rtl/dfi_rddata_realign.sv
// rtl/dfi_rddata_realign.sv - per-phase DFI read-return FIFOs re-emitting phase-aligned beats
// Tracks outstanding beats against rddata_en and flags overflow, unexpected data and timeouts.
module dfi_rddata_realign #(
  parameter int PHASE_DW = 32,
  parameter int DEPTH    = 8,
  parameter int CNT_W    = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rden_issue,
  input  logic [4*PHASE_DW-1:0] phy_rddata,
  input  logic [3:0]            phy_rddata_valid,
  input  logic [7:0]            timeout_cfg,
  input  logic                  clr_err,
  output logic [4*PHASE_DW-1:0] out_rddata,
  output logic [3:0]            out_rddata_valid,
  output logic [CNT_W-1:0]      outstanding,
  output logic                  err_overflow,
  output logic                  err_unexpected,
  output logic                  err_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [3:0]            full;
  logic [3:0]            empty;
  logic [3:0]            wr_en;
  logic [3:0]            ovf_hit;
  logic [4*PHASE_DW-1:0] lane_head;
  logic [7:0]            tcnt;
  logic                  flush;
  logic                  pop;

  assign flush = (timeout_cfg != 8'd0) && (tcnt == timeout_cfg);
  assign pop   = ~|empty && !flush;

  for (genvar p = 0; p < 4; p++) begin : g_lane
    logic [PHASE_DW-1:0] mem [DEPTH];
    logic [AW:0]         wptr;
    logic [AW:0]         rptr;

    assign empty[p] = (wptr == rptr);
    assign full[p]  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    // A full lane that is popped this cycle frees its slot in time for the write.
    assign wr_en[p]   = phy_rddata_valid[p] && !flush && (!full[p] || pop);
    assign ovf_hit[p] = phy_rddata_valid[p] && !flush && full[p] && !pop;
    assign lane_head[p*PHASE_DW +: PHASE_DW] = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
      if (wr_en[p]) begin
        mem[wptr[AW-1:0]] <= phy_rddata[p*PHASE_DW +: PHASE_DW];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wptr <= '0;
        rptr <= '0;
      end else if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (wr_en[p]) wptr <= wptr + (AW+1)'(1);
        if (pop)      rptr <= rptr + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      tcnt        <= '0;
    end else if (flush) begin
      outstanding <= '0;
      tcnt        <= '0;
    end else begin
      if (rden_issue && !pop && outstanding != CNT_MAX) begin
        outstanding <= outstanding + CNT_W'(1);
      end else if (pop && !rden_issue && outstanding != '0) begin
        outstanding <= outstanding - CNT_W'(1);
      end
      tcnt <= (outstanding == '0 || pop) ? 8'd0 : tcnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_rddata       <= '0;
      out_rddata_valid <= '0;
    end else begin
      out_rddata_valid <= {4{pop}};
      if (pop) out_rddata <= lane_head;
    end
  end

  // Set wins over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overflow   <= 1'b0;
      err_unexpected <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      err_overflow   <= (|ovf_hit) | (err_overflow & ~clr_err);
      err_unexpected <= (pop && outstanding == '0) | (err_unexpected & ~clr_err);
      err_timeout    <= flush | (err_timeout & ~clr_err);
    end
  end

endmodule
